// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Instruction memory with a registered one-cycle fetch port and a
//             byte-serial program-load port (IDLE/LOAD session control).
//  Option   : define IMEM_PARITY_EN to store an even-parity bit per word and
//             flag parity mismatches on fetch via fetch_err.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 8,
  parameter int DEPTH             = 256,
  parameter int LOAD_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_req,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic                         fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         fetch_err,
  input  logic                         load_en,
  input  logic                         load_valid,
  input  logic [LOAD_WIDTH-1:0]        load_data,
  output logic                         load_ready,
  output logic                         load_done,
  output logic [PC_WIDTH:0]            load_count,
  output logic                         busy
);

  localparam int BPW    = (INSTRUCTION_WIDTH + LOAD_WIDTH - 1) / LOAD_WIDTH;
  localparam int ASM_W  = BPW * LOAD_WIDTH;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PC_WIDTH + 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W  = INSTRUCTION_WIDTH + 1;
`else
  localparam int MEM_W  = INSTRUCTION_WIDTH;
`endif

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BPW - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [BIDX_W-1:0]              byte_idx_q, byte_idx_d;
  logic [ASM_W-1:0]               asm_q, asm_d;
  logic [CNT_W-1:0]               load_count_q, load_count_d;
  logic                           load_done_q, load_done_d;
  logic                           fetch_valid_q, fetch_valid_d;
  logic [INSTRUCTION_WIDTH-1:0]   instruction_q, instruction_d;
  logic                           fetch_err_q, fetch_err_d;

  // Program store; deliberately not reset so contents survive a reset
  logic [MEM_W-1:0]               mem_q [DEPTH];

  logic                           w_load_ready;
  logic                           w_accept;
  logic                           w_wr_en;
  logic [MEM_W-1:0]               w_wr_word;
  logic [MEM_W-1:0]               w_rd_word;
  logic                           w_pc_in_range;

  // Write address is the completed-word count, so no separate address flop
  assign w_load_ready  = (state_q == ST_LOAD) && (load_count_q < DEPTH_C);
  assign w_accept      = load_valid && w_load_ready;
  assign w_pc_in_range = ({1'b0, pc} < DEPTH_C);

  // Load session control: byte assembly, word commit and session entry/exit
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    load_count_d = load_count_q;
    load_done_d  = 1'b0;
    w_wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d      = ST_LOAD;
          byte_idx_d   = '0;
          asm_d        = '0;
          load_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          // LSB-first placement; bits above the instruction width are dropped at write
          for (int k = 0; k < BPW; k++) begin
            if (byte_idx_q == k[BIDX_W-1:0]) begin
              asm_d[k*LOAD_WIDTH +: LOAD_WIDTH] = load_data;
            end
          end
          if (byte_idx_q == LAST_IDX) begin
            w_wr_en      = 1'b1;
            byte_idx_d   = '0;
            load_count_d = load_count_q + CNT_W'(1);
          end else begin
            byte_idx_d   = byte_idx_q + BIDX_W'(1);
          end
        end
        if (!load_en) begin
          // Leaving the session discards any partially assembled word
          state_d     = ST_IDLE;
          byte_idx_d  = '0;
          load_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {^asm_d[INSTRUCTION_WIDTH-1:0], asm_d[INSTRUCTION_WIDTH-1:0]};
`else
  assign w_wr_word = asm_d[INSTRUCTION_WIDTH-1:0];
`endif

  // Fetch response: array is read only in IDLE and only for in-range pc
  always_comb begin
    fetch_valid_d = fetch_req;
    instruction_d = instruction_q;
    fetch_err_d   = fetch_err_q;
    w_rd_word     = '0;
    if (fetch_req) begin
      if ((state_q == ST_IDLE) && w_pc_in_range) begin
        w_rd_word     = mem_q[pc[AW-1:0]];
        instruction_d = w_rd_word[INSTRUCTION_WIDTH-1:0];
`ifdef IMEM_PARITY_EN
        fetch_err_d   = (^w_rd_word[INSTRUCTION_WIDTH-1:0]) != w_rd_word[INSTRUCTION_WIDTH];
`else
        fetch_err_d   = 1'b0;
`endif
      end else begin
        instruction_d = '0;
        fetch_err_d   = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      load_count_q  <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      instruction_q <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      load_count_q  <= load_count_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
      instruction_q <= instruction_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Word commit on the edge that accepts the last byte of a word
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      mem_q[load_count_q[AW-1:0]] <= w_wr_word;
    end
  end

  assign load_ready  = w_load_ready;
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;
  assign busy        = (state_q == ST_LOAD);
  assign fetch_valid = fetch_valid_q;
  assign instruction = instruction_q;
  assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with a registered fetch port and a byte-serial program-load port. It replaces the file-initialised, combinationally read instruction store: the core fetches with a one-cycle handshake, and a host or debug bridge can stream a new program into the array at run time. It sits between the PC generator and the decode stage; the loader side attaches to the host byte link.

## Interface
- `INSTRUCTION_WIDTH`, 40: instruction word width in bits.
- `PC_WIDTH`, 8: fetch/load address width.
- `DEPTH`, 256: number of words, ≤ 2**PC_WIDTH.
- `LOAD_WIDTH`, 8: load byte width; BPW = ceil(INSTRUCTION_WIDTH/LOAD_WIDTH) bytes per word (5 at defaults).

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: synchronous, active-low reset.
- `fetch_req` input 1: fetch request for `pc` this cycle.
- `pc` input PC_WIDTH: fetch address.
- `fetch_valid` output 1: `instruction`/`fetch_err` valid this cycle.
- `instruction` output INSTRUCTION_WIDTH: fetched word.
- `fetch_err` output 1: fetch failed or suspect.
- `load_en` input 1: level; requests/holds load session.
- `load_valid` input 1: `load_data` valid.
- `load_data` input LOAD_WIDTH: program byte.
- `load_ready` output 1: byte accepted when `load_valid && load_ready`.
- `load_done` output 1: one-cycle pulse on leaving LOAD.
- `load_count` output PC_WIDTH+1: complete words written in last/current session.
- `busy` output 1: high while in LOAD.

## Operation
- States: IDLE, LOAD. IDLE→LOAD when `load_en`=1; LOAD→IDLE when `load_en`=0. `load_done` pulses the cycle after the LOAD→IDLE transition.
- On IDLE→LOAD: write address, byte index and `load_count` cleared to 0.
- Loading: accepted byte k (0..BPW-1) fills bits [k·LOAD_WIDTH +: LOAD_WIDTH] (LSB first); bits above INSTRUCTION_WIDTH in the last byte are dropped.
- On acceptance of byte BPW-1 the assembled word (including that byte) is written to the current address in the same edge; address and `load_count` increment, byte index returns to 0.
- Full: once `load_count`=DEPTH, `load_ready`=0 for the rest of the session; no wrap, no overwrite of word 0.
- Exit with partial word: partial bytes discarded, memory and `load_count` unaffected.
- `load_ready` = (state==LOAD) && (`load_count` < DEPTH).
- Fetch: `fetch_req` in IDLE reads `memory[pc]`.
  - If `pc` ≥ DEPTH: `instruction`=0, `fetch_err`=1.
  - `fetch_req` while in LOAD: response still returned with `instruction`=0, `fetch_err`=1. The array is never read during load.
- Memory contents are not cleared by reset; they are undefined until loaded.

## Timing
- Fetch latency: 1 cycle. A request at edge N gives `fetch_valid`=1 with data after edge N. Back-to-back requests are supported at one per cycle. `fetch_valid`=0 when there was no request in the prior cycle; `instruction` holds its last value.
- Same-cycle fetch and LOAD entry: the fetch is evaluated against the pre-edge state (IDLE) and returns memory data.
- Load throughput: one byte per cycle; one word per BPW accepted bytes.
- Reset values: `fetch_valid`=0, `instruction`=0, `fetch_err`=0, `load_ready`=0, `load_done`=0, `load_count`=0, `busy`=0, state IDLE.
- Reset mid-load: returns to IDLE and discards the partial word. Words already written are retained. `load_done` does not pulse.

## Configuration
- `IMEM_PARITY_EN` defined:
  - Each word stores one extra even-parity bit (XOR of the word), computed at write.
  - On fetch, parity is recomputed; a mismatch sets `fetch_err`=1 while the stored word is still returned on `instruction`.
- Undefined: no parity storage. `fetch_err` covers only out-of-range and fetch-during-load.

## Test plan
- Load 2 words, bytes 01,02,03,04,05,0A,0B,0C,0D,0E, then drop `load_en`:
  - `load_done` pulses once and `load_count`=2.
  - Fetch pc=0 returns 0x0504030201; pc=1 returns 0x0E0D0C0B0A, each with 1-cycle latency and `fetch_err`=0.
- Fill DEPTH=4 build with 5 words of bytes:
  - `load_ready` drops after the 20th byte and `load_count`=4.
  - The 5th word is never accepted; word 0 is unchanged.
- Send 3 bytes, then drop `load_en`: `load_count` is unchanged and the target word keeps its old contents.
- Fetch pc=3,4,5 on consecutive cycles in a DEPTH=4, PC_WIDTH=3 build: responses come back-to-back, and pc=4/5 give `instruction`=0, `fetch_err`=1.
- Assert `rst_n`=0 after 7 bytes:
  - Outputs reach their reset values at the next edge and the state is IDLE.
  - Word 0 is retained, word 1 is not written, and there is no `load_done` pulse.
- With `IMEM_PARITY_EN`: load 0x0000000001, force its parity bit flipped, fetch it. Expect `instruction`=0x0000000001 and `fetch_err`=1. Without the macro the same fetch gives `fetch_err`=0.
